// File: rtl/npc_csr_pkg.sv
// npc_csr_pkg: shared Zicsr funct3 encodings, well-known CSR addresses and executor state type.
package npc_csr_pkg;
  localparam logic [2:0] CSR_RW  = 3'b001;
  localparam logic [2:0] CSR_RS  = 3'b010;
  localparam logic [2:0] CSR_RC  = 3'b011;
  localparam logic [2:0] CSR_RWI = 3'b101;
  localparam logic [2:0] CSR_RSI = 3'b110;
  localparam logic [2:0] CSR_RCI = 3'b111;
  localparam logic [11:0] MCYCLE    = 12'hb00;
  localparam logic [11:0] MCYCLEH   = 12'hb80;
  localparam logic [11:0] MVENDORID = 12'hf11;
  localparam logic [11:0] MARCHID   = 12'hf12;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_COMMIT} state_e;
  // low two funct3 bits select RW/RS/RC; 00 is not a CSR op
  function automatic logic kind_valid(input logic [1:0] kind);
    return kind != 2'b00;
  endfunction
endpackage

// File: rtl/csr_alu.sv
// csr_alu: combinational new-value computation for csrrw/csrrs/csrrc and their immediate forms.
module csr_alu
  import npc_csr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      i_kind,
  input  logic [XLEN-1:0] i_old,
  input  logic [XLEN-1:0] i_operand,
  output logic [XLEN-1:0] o_new
);
  always_comb
    o_new = (i_kind == CSR_RW[1:0]) ? i_operand :
            (i_kind == CSR_RS[1:0]) ? (i_old | i_operand) :
            (i_kind == CSR_RC[1:0]) ? (i_old & ~i_operand) : i_old;
endmodule

// File: rtl/csr_exec.sv
// csr_exec: three-state (IDLE/READ/COMMIT) Zicsr executor driving the CSR port and a GPR write port.
// Optional CSR_EXEC_ILLEGAL_CHECK_EN flags invalid ops and writes to read-only CSRs.
module csr_exec
  import npc_csr_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int GPR_AW = 5,
  parameter int CSR_AW = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [CSR_AW-1:0] in_csr_addr,
  input  logic [GPR_AW-1:0] in_rs1_idx,
  input  logic [XLEN-1:0]   in_rs1_data,
  input  logic [4:0]        in_zimm,
  input  logic [GPR_AW-1:0] in_rd,
  input  logic              flush,
  output logic [CSR_AW-1:0] csr_addr,
  input  logic [XLEN-1:0]   csr_rdata,
  output logic              csr_wen,
  output logic [XLEN-1:0]   csr_wdata,
  output logic              gpr_wen,
  output logic [GPR_AW-1:0] gpr_waddr,
  output logic [XLEN-1:0]   gpr_wdata,
  output logic              done,
  output logic              illegal
);
  state_e            r_state, w_next;
  logic [1:0]        r_kind;
  logic [CSR_AW-1:0] r_addr;
  logic [XLEN-1:0]   r_operand, r_old;
  logic [GPR_AW-1:0] r_rd;
  logic              r_wn;
  logic [XLEN-1:0]   w_operand, w_new;
  logic              w_wn, w_ill, w_ok;
  assign in_ready  = (r_state == S_IDLE);
  assign w_operand = in_op[2] ? {{(XLEN-5){1'b0}}, in_zimm} : in_rs1_data;
  // RS/RC only write when the source is nonzero (rs1 index for register forms, zimm for immediates)
  assign w_wn      = (in_op[1:0] == CSR_RW[1:0]) || (in_op[2] ? (in_zimm != '0) : (in_rs1_idx != '0));
`ifdef CSR_EXEC_ILLEGAL_CHECK_EN
  assign w_ill = !kind_valid(r_kind) || (r_wn && r_addr[CSR_AW-1:CSR_AW-2] == 2'b11);
`else
  assign w_ill = 1'b0;
`endif
  assign w_ok = kind_valid(r_kind) && !w_ill;
  csr_alu #(.XLEN(XLEN)) u_alu (
    .i_kind    (r_kind),
    .i_old     (r_old),
    .i_operand (r_operand),
    .o_new     (w_new)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_kind    <= '0;
      r_addr    <= '0;
      r_operand <= '0;
      r_rd      <= '0;
      r_wn      <= 1'b0;
      r_old     <= '0;
    end else begin
      r_state <= w_next;
      if (in_valid && in_ready) begin
        r_kind    <= in_op[1:0];
        r_addr    <= in_csr_addr;
        r_operand <= w_operand;
        r_rd      <= in_rd;
        r_wn      <= w_wn;
      end
      if (r_state == S_READ) r_old <= csr_rdata;
    end
  end
  always_comb begin
    w_next    = r_state;
    csr_addr  = '0;
    csr_wen   = 1'b0;
    csr_wdata = '0;
    gpr_wen   = 1'b0;
    gpr_waddr = '0;
    gpr_wdata = '0;
    done      = 1'b0;
    illegal   = 1'b0;
    case (r_state)
      S_IDLE: w_next = in_valid ? S_READ : S_IDLE;
      S_READ: begin
        w_next   = flush ? S_IDLE : S_COMMIT;
        csr_addr = r_addr;
      end
      S_COMMIT: begin
        w_next    = S_IDLE;
        csr_addr  = r_addr;
        csr_wen   = w_ok && r_wn;
        csr_wdata = w_new;
        gpr_wen   = w_ok && (r_rd != '0);
        gpr_waddr = r_rd;
        gpr_wdata = r_old;
        done      = 1'b1;
        illegal   = w_ill;
      end
      default: w_next = S_IDLE;
    endcase
  end
endmodule

// File: doc/csr_exec.md
# csr_exec

Multi-cycle executor for Zicsr instructions (csrrw/csrrs/csrrc and immediate forms) in the NPC core. It sits between decode and the register file and drives both ends of that interface. On the CSR side it reads the old value, computes the new value and issues the CSR write. On the GPR side it writes the old CSR value to rd. It is the initiator for the register file's CSR port and GPR write port.

## Interface
Parameters:
- XLEN, 32, data width of GPRs and CSRs
- GPR_AW, 5, GPR index width
- CSR_AW, 12, CSR address width

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoded CSR instruction present
- in_ready  out  1  executor idle and able to accept
- in_op  in  3  funct3 of instruction
- in_csr_addr  in  CSR_AW  CSR address
- in_rs1_idx  in  GPR_AW  rs1 index (zero test)
- in_rs1_data  in  XLEN  rs1 value
- in_zimm  in  5  immediate field (i-forms)
- in_rd  in  GPR_AW  destination GPR
- flush  in  1  abort in-flight instruction
- csr_addr  out  CSR_AW  CSR address, shared by read and write
- csr_rdata  in  XLEN  combinational CSR read data
- csr_wen  out  1  CSR write strobe
- csr_wdata  out  XLEN  CSR write data
- gpr_wen  out  1  GPR write strobe
- gpr_waddr  out  GPR_AW  GPR write index
- gpr_wdata  out  XLEN  GPR write data
- done  out  1  one-cycle completion pulse
- illegal  out  1  one-cycle illegal pulse (see Configuration)

## Operation
- FSM states: IDLE, READ, COMMIT.
  - IDLE → READ on in_valid && in_ready; latch op, addr, operand, rd and a write_needed flag.
  - READ → COMMIT unconditionally, unless flush is high, in which case READ → IDLE.
  - COMMIT → IDLE always; flush is ignored in COMMIT.
- in_ready = (state == IDLE).
- Operand selection:
  - in_op[2] = 0: operand = in_rs1_data.
  - in_op[2] = 1: operand = zero-extended in_zimm.
- READ:
  - csr_addr is driven with the latched address.
  - csr_rdata is captured into the old-value register at the end of the cycle.
- New value:
  - RW (001/101): operand.
  - RS (010/110): old | operand.
  - RC (011/111): old & ~operand.
- write_needed:
  - RW forms: always 1.
  - RS/RC register forms: 1 iff in_rs1_idx != 0.
  - RS/RC immediate forms: 1 iff in_zimm != 0.
- COMMIT:
  - csr_wen = write_needed, csr_wdata = new value, csr_addr held.
  - gpr_wen = (rd != 0), gpr_waddr = rd, gpr_wdata = old value.
  - done = 1.
  - CSR and GPR writes occur in the same cycle.
- Ops 000 and 100 are invalid:
  - They still traverse READ/COMMIT.
  - csr_wen = 0, gpr_wen = 0, done = 1.
- All arithmetic is XLEN wide; zimm is zero-extended, never sign-extended.

## Timing
- Reset values: state IDLE; in_ready 1; csr_addr, csr_wen, csr_wdata, gpr_wen, gpr_waddr, gpr_wdata, done, illegal all 0.
- Accept at edge N; READ in cycle N+1; COMMIT (strobes) in cycle N+2; in_ready high again in cycle N+3.
- Throughput: one instruction per 3 cycles.
- All strobes are high for exactly one cycle. Outputs are 0 outside COMMIT, except csr_addr, which is also valid in READ.
- Reset asserted mid-operation: return to IDLE immediately with no strobes, including when asserted during COMMIT.
- Flush in the acceptance cycle has no effect; the instruction is already latched and is aborted in READ.

## Configuration
- Macro: CSR_EXEC_ILLEGAL_CHECK_EN.
- Defined:
  - An instruction is illegal if its op is invalid, or if write_needed && csr_addr[11:10] == 2'b11 (read-only CSR).
  - An illegal instruction suppresses csr_wen and gpr_wen in COMMIT and pulses illegal together with done.
- Undefined:
  - illegal is tied to 0.
  - Read-only writes are issued; the CSR file drops them.
  - Invalid ops behave as described in Operation.

## Structure
- Shared package npc_csr_pkg:
  - funct3 constants CSR_RW/RS/RC/RWI/RSI/RCI.
  - CSR address constants MCYCLE 12'hb00, MCYCLEH 12'hb80, MVENDORID 12'hf11, MARCHID 12'hf12.
  - State enum.
- One combinational sub-module, csr_alu:
  - Inputs: op, old, operand.
  - Output: new value.
- The FSM, latches and strobes stay in csr_exec.

## Test plan
- csrrw, addr 0xb00, rs1_data 0x1234, rd 5, csr_rdata 0x40 → COMMIT: csr_wen=1, csr_wdata=0x1234; gpr_wen=1, waddr 5, wdata 0x40; done=1.
- csrrs, addr 0xf11, rs1_idx 0, rd 10, csr_rdata 0x79737978 → csr_wen=0; gpr_wen=1, waddr 10, wdata 0x79737978.
- csrrci, zimm 3, rd 0, csr_rdata 0xFF → csr_wdata=0xFC, csr_wen=1, gpr_wen=0.
- Flush during READ → no strobes at all; in_ready=1 in the following cycle; the next accepted instruction completes normally.
- csrrw to 0xf12: with the macro → illegal=1, done=1, csr_wen=0, gpr_wen=0; without the macro → csr_wen=1, illegal=0.
- rst_n low during COMMIT → all outputs 0 immediately, in_ready=1; after release, back-to-back in_valid is accepted on the first edge.
